// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared types and constants for the load/store unit.
//                - lsu_state_t : FSM state encoding
//                - F3_*        : RV32I load/store funct3 codes
//                - CAUSE_*     : fault cause codes reported on fault_cause
//  Revision    : 1.0  initial release
// ============================================================================
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } lsu_state_t;

  // funct3[1:0] gives the access size, funct3[2] marks the unsigned loads.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit_if
//  Description : Handshaked memory bus between the load/store unit and memory.
//                bus_req   : request, held until bus_ack
//                bus_we    : write strobe
//                bus_addr  : word-aligned byte address
//                bus_be    : byte enables
//                bus_wdata : lane-replicated store data
//                bus_ack   : memory accepted/completed the access this cycle
//                bus_rdata : read word, valid together with bus_ack
//                modport master : load/store unit side
//                modport slave  : memory side
//  Revision    : 1.0  initial release
// ============================================================================
interface load_store_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface : load_store_unit_if
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_lane_align
//  Description : Combinational lane logic for the load/store unit.
//                Checks funct3 legality and alignment, builds byte enables and
//                lane-replicated store data, and extracts/extends load data.
//  Ports       : i_funct3      funct3 of the access
//                i_write       1 = store, 0 = load
//                i_offset      byte offset within the word (addr[1:0])
//                i_wdata       raw store data (rs2)
//                i_rdata       raw read word from the bus
//                o_be          byte enables (1111 for loads)
//                o_wdata       replicated store data (0 for loads)
//                o_misaligned  access crosses its natural alignment
//                o_illegal     funct3 not valid for this access direction
//                o_load_data   selected and sign/zero-extended load result
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic        i_write,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misaligned,
  output logic        o_illegal,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_be         = 4'b0000;
    o_wdata      = 32'h0;
    o_misaligned = 1'b0;
    o_illegal    = 1'b0;
    o_load_data  = 32'h0;
    w_byte       = i_rdata[{i_offset, 3'b000} +: 8];
    w_half       = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

    if (i_write) begin
      o_illegal = !((i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W));
    end else begin
      o_illegal = !((i_funct3 == F3_B)  || (i_funct3 == F3_H) || (i_funct3 == F3_W) ||
                    (i_funct3 == F3_BU) || (i_funct3 == F3_HU));
    end

    case (i_funct3[1:0])
      2'b01:   o_misaligned = i_offset[0];
      2'b10:   o_misaligned = |i_offset;
      default: o_misaligned = 1'b0;
    endcase

    if (i_write) begin
      case (i_funct3[1:0])
        2'b00: begin
          o_be    = 4'b0001 << i_offset;
          o_wdata = {4{i_wdata[7:0]}};
        end
        2'b01: begin
          o_be    = i_offset[1] ? 4'b1100 : 4'b0011;
          o_wdata = {2{i_wdata[15:0]}};
        end
        default: begin
          o_be    = 4'b1111;
          o_wdata = i_wdata;
        end
      endcase
    end else begin
      o_be = 4'b1111;
    end

    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_BU:   o_load_data = {24'h0, w_byte};
      F3_HU:   o_load_data = {16'h0, w_half};
      default: o_load_data = i_rdata;
    endcase
  end

endmodule : lsu_lane_align
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Multi-cycle load/store engine between the core datapath and a
//                handshaked memory bus. Stalls the core while a bus access is
//                outstanding and aborts an access after TIMEOUT bus cycles
//                without an acknowledge.
//  Parameters  : TIMEOUT      bus cycles without bus_ack before abort (>=1)
//  Ports       : clk, reset   clock, synchronous active-high reset
//                req_valid    core presents a load/store this cycle
//                req_write    1 = store, 0 = load
//                req_funct3   RV32I funct3
//                req_addr     byte address
//                req_wdata    store data (rs2)
//                stall        hold PC / register-file write while high
//                load_data    extracted load result (0 after stores/faults)
//                load_valid   1-cycle pulse, access complete
//                fault        1-cycle pulse, access aborted
//                fault_cause  01 misaligned, 10 illegal funct3, 11 timeout
//                bus          memory bus (master side)
//  Revision    : 1.0  initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic                     req_write,
  input  logic [2:0]               req_funct3,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     stall,
  output logic [31:0]              load_data,
  output logic                     load_valid,
  output logic                     fault,
  output logic [1:0]               fault_cause,
  load_store_unit_if.master        bus
);

  localparam int              c_CW   = $clog2(TIMEOUT + 1);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(TIMEOUT - 1);

  lsu_state_t      r_state;
  logic [c_CW-1:0] r_cnt;
  logic [2:0]      r_funct3;
  logic [1:0]      r_offset;
  logic            r_write;

  logic [2:0]      w_funct3;
  logic [1:0]      w_offset;
  logic            w_write;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata;
  logic            w_misaligned;
  logic            w_illegal;
  logic [31:0]     w_load_data;

  // In IDLE the lane logic looks at the incoming request for legality and
  // lane generation; once the bus is busy it looks at the latched fields so
  // the returning read word is extracted with the original offset/size.
  assign w_funct3 = (r_state == IDLE) ? req_funct3    : r_funct3;
  assign w_offset = (r_state == IDLE) ? req_addr[1:0] : r_offset;
  assign w_write  = (r_state == IDLE) ? req_write     : r_write;

  lsu_lane_align u_lane (
    .i_funct3     (w_funct3),
    .i_write      (w_write),
    .i_offset     (w_offset),
    .i_wdata      (req_wdata),
    .i_rdata      (bus.bus_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_misaligned (w_misaligned),
    .o_illegal    (w_illegal),
    .o_load_data  (w_load_data)
  );

  // Same-cycle stall in IDLE so the core never advances past a memory
  // instruction before the FSM has latched it.
  assign stall = (r_state == IDLE) ? req_valid : (r_state == BUS);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_funct3      <= 3'b000;
      r_offset      <= 2'b00;
      r_write       <= 1'b0;
      load_data     <= 32'h0;
      load_valid    <= 1'b0;
      fault         <= 1'b0;
      fault_cause   <= CAUSE_NONE;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= 32'h0;
      bus.bus_be    <= 4'b0000;
      bus.bus_wdata <= 32'h0;
    end else begin
      load_valid  <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= CAUSE_NONE;

      case (r_state)
        IDLE: begin
          if (req_valid) begin
            if (w_illegal) begin
              fault       <= 1'b1;
              fault_cause <= CAUSE_ILLEGAL;
              load_data   <= 32'h0;
              r_state     <= FAULT;
            end else if (w_misaligned) begin
              fault       <= 1'b1;
              fault_cause <= CAUSE_MISALIGN;
              load_data   <= 32'h0;
              r_state     <= FAULT;
            end else begin
              r_funct3      <= req_funct3;
              r_offset      <= req_addr[1:0];
              r_write       <= req_write;
              r_cnt         <= '0;
              bus.bus_req   <= 1'b1;
              bus.bus_we    <= req_write;
              bus.bus_addr  <= {req_addr[31:2], 2'b00};
              bus.bus_be    <= w_be;
              bus.bus_wdata <= w_wdata;
              r_state       <= BUS;
            end
          end
        end

        BUS: begin
          if (bus.bus_ack) begin
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= 32'h0;
            bus.bus_be    <= 4'b0000;
            bus.bus_wdata <= 32'h0;
            load_data     <= r_write ? 32'h0 : w_load_data;
            load_valid    <= 1'b1;
            r_state       <= DONE;
          end else if (r_cnt == c_LAST) begin
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= 32'h0;
            bus.bus_be    <= 4'b0000;
            bus.bus_wdata <= 32'h0;
            load_data     <= 32'h0;
            fault         <= 1'b1;
            fault_cause   <= CAUSE_TIMEOUT;
            r_state       <= FAULT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        DONE:    r_state <= IDLE;
        FAULT:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule : load_store_unit
`default_nettype wire
